// File: rtl/counter_prog_pkg.sv
// rtl/counter_prog_pkg.sv - mode and direction encodings shared by the programmable counter
package counter_prog_pkg;

  localparam logic [2:0] MODE_BINARY  = 3'd0;
  localparam logic [2:0] MODE_RING1   = 3'd1;
  localparam logic [2:0] MODE_RING2   = 3'd2;
  localparam logic [2:0] MODE_JUMP2   = 3'd3;
  localparam logic [2:0] MODE_JOHNSON = 3'd4;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_prog_next.sv
// rtl/counter_prog_next.sv - combinational next-count and wrap computation for every counting mode
//   count      in   WIDTH  current registered count
//   mode       in   3      counting mode (see counter_prog_pkg)
//   direction  in   1      0 = up/left, 1 = down/right
//   next_count out  WIDTH  value the count takes on an enabled edge
//   next_wrap  out  1      wrap flag accompanying next_count
//   COUNTER_PROG_JOHNSON_EN: when defined, mode 4 is a Johnson counter; otherwise it counts in binary
module counter_prog_next
  import counter_prog_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] START_COUNT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic [WIDTH-1:0] count,
  input  logic [2:0]       mode,
  input  logic             direction,
  output logic [WIDTH-1:0] next_count,
  output logic             next_wrap
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
  localparam logic [WIDTH:0]   TWO_W   = (WIDTH+1)'(2);
  localparam logic [WIDTH:0]   MODULUS = {1'b0, MAX_COUNT} + {{WIDTH{1'b0}}, 1'b1};

  // Out-of-range values (possible after a mode switch from a ring pattern)
  // are treated as the terminal value by the arithmetic modes.
  logic [WIDTH-1:0] arith;
  logic [WIDTH:0]   sum;
  int unsigned      shift;

  assign arith = (count > MAX_COUNT) ? MAX_COUNT : count;

  always_comb begin
    next_count = arith + ONE;
    next_wrap  = 1'b0;
    sum        = '0;
    shift      = (mode == MODE_RING2) ? 2 : 1;
    case (mode)
      MODE_RING1, MODE_RING2: begin
        if (count == '0) begin
          // An empty ring would never recover; reseed it.
          next_count = START_COUNT;
        end else if (direction == DIR_UP) begin
          next_count = (count << shift) | (count >> (WIDTH - shift));
          next_wrap  = |(count >> (WIDTH - shift));
        end else begin
          next_count = (count >> shift) | (count << (WIDTH - shift));
          next_wrap  = |(count & ((ONE << shift) - ONE));
        end
      end
      MODE_JUMP2: begin
        if (direction == DIR_UP) begin
          sum = {1'b0, arith} + TWO_W;
          if (sum >= MODULUS) begin
            sum       = sum - MODULUS;
            next_wrap = 1'b1;
          end
        end else if (arith < TWO) begin
          sum       = {1'b0, arith} + MODULUS - TWO_W;
          next_wrap = 1'b1;
        end else begin
          sum = {1'b0, arith} - TWO_W;
        end
        next_count = sum[WIDTH-1:0];
      end
`ifdef COUNTER_PROG_JOHNSON_EN
      MODE_JOHNSON: begin
        if (direction == DIR_UP)
          next_count = {count[WIDTH-2:0], ~count[WIDTH-1]};
        else
          next_count = {~count[0], count[WIDTH-1:1]};
        next_wrap = (next_count == '0);
      end
`endif
      default: begin
        if (direction == DIR_UP) begin
          next_wrap  = (arith == MAX_COUNT);
          next_count = next_wrap ? '0 : arith + ONE;
        end else begin
          next_wrap  = (arith == '0);
          next_count = next_wrap ? MAX_COUNT : arith - ONE;
        end
      end
    endcase
  end

endmodule

// File: rtl/counter_prog_param.sv
// rtl/counter_prog_param.sv - parametrised programmable pattern counter with load and wrap pulse
//   clk         in   1      clock, rising edge
//   reset       in   1      asynchronous, active-high
//   enable      in   1      advance one step
//   mode        in   3      0 binary, 1 ring1, 2 ring2, 3 jump2, 4 johnson/binary, others binary
//   direction   in   1      0 = up/left, 1 = down/right
//   load        in   1      synchronous parallel load (beats enable)
//   load_value  in   WIDTH  value captured on load, clamped to MAX_COUNT
//   count       out  WIDTH  registered count/pattern
//   wrap        out  1      one-cycle pulse coinciding with the wrapped count
//   COUNTER_PROG_JOHNSON_EN: enables the Johnson sequence on mode 4
module counter_prog_param
  import counter_prog_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] START_COUNT = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic             direction,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  counter_prog_next #(
    .WIDTH       (WIDTH),
    .MAX_COUNT   (MAX_COUNT),
    .START_COUNT (START_COUNT)
  ) u_next (
    .count      (count),
    .mode       (mode),
    .direction  (direction),
    .next_count (next_count),
    .next_wrap  (next_wrap)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= START_COUNT;
      wrap  <= 1'b0;
    end else if (load) begin
      count <= (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
      wrap  <= 1'b0;
    end else if (enable) begin
      count <= next_count;
      wrap  <= next_wrap;
    end else begin
      wrap  <= 1'b0;
    end
  end

endmodule
